// File: rtl/mercury2_dac_spi.sv
// mercury2_dac_spi: 16-bit SPI frame generator and LDAC sequencer for the Mercury2 MCP48x2 dual DAC.
module mercury2_dac_spi #(
    parameter int DATA_WIDTH = 10,
    parameter int SCK_DIV    = 2,
    parameter bit LDAC_MODE  = 1'b0,
    parameter int LDAC_WIDTH = 2,
    parameter bit GAIN_2X    = 1'b0
) (
    input  logic                  clk_50MHZ,
    input  logic                  rst_n,
    input  logic                  trigger,
    input  logic                  channel,
    input  logic [DATA_WIDTH-1:0] Din,
    input  logic                  update,
    output logic                  Busy,
    output logic                  dac_csn,
    output logic                  dac_sdi,
    output logic                  dac_sck,
    output logic                  dac_ldac,
    output logic [DATA_WIDTH-1:0] value0,
    output logic [DATA_WIDTH-1:0] value1
);
    localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, SHIFT = 3'd2, HOLD = 3'd3, GAP = 3'd4, LDAC = 3'd5;
    localparam int CW = $clog2((SCK_DIV > LDAC_WIDTH ? SCK_DIV : LDAC_WIDTH) + 1);
    localparam logic [CW-1:0] D_LAST = CW'(SCK_DIV - 1);
    localparam logic [CW-1:0] W_LAST = CW'(LDAC_WIDTH - 1);
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_cnt;
    logic [15:0]   shreg;
    logic [15:0]   frame;
    logic          pending, d_end, w_end, upd;
    assign frame = {channel, 1'b0, ~GAIN_2X, 1'b1, 12'(Din) << (12 - DATA_WIDTH)};
    assign d_end = cnt == D_LAST;
    assign w_end = cnt == W_LAST;
    assign upd   = LDAC_MODE & update;
    always_ff @(posedge clk_50MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            pending  <= 1'b0;
            Busy     <= 1'b0;
            dac_csn  <= 1'b1;
            dac_sdi  <= 1'b0;
            dac_sck  <= 1'b0;
            dac_ldac <= 1'b1;
            value0   <= '0;
            value1   <= '0;
        end else begin
            cnt <= (state == IDLE || (state == LDAC ? w_end : d_end)) ? '0 : cnt + 1'b1;
            if (upd && state != IDLE) pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state   <= SETUP;
                        shreg   <= frame;
                        bit_cnt <= '0;
                        dac_csn <= 1'b0;
                        dac_sdi <= frame[15];
                        Busy    <= 1'b1;
                        pending <= pending | upd;
                        if (channel) value1 <= Din;
                        else value0 <= Din;
                    end else if (upd || pending) begin
                        state    <= LDAC;
                        dac_ldac <= 1'b0;
                        Busy     <= 1'b1;
                        pending  <= 1'b0;
                    end
                end
                SETUP: if (d_end) state <= SHIFT;
                // dac_sck doubles as the half-bit phase; sdi only moves when a low phase begins
                SHIFT: if (d_end) begin
                    if (!dac_sck) dac_sck <= 1'b1;
                    else begin
                        dac_sck <= 1'b0;
                        if (bit_cnt == 4'd15) state <= HOLD;
                        else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= {shreg[14:0], 1'b0};
                            dac_sdi <= shreg[14];
                        end
                    end
                end
                HOLD: if (d_end) begin
                    state   <= GAP;
                    dac_csn <= 1'b1;
                    dac_sdi <= 1'b0;
                end
                GAP: if (d_end) begin
                    if (!LDAC_MODE || pending || upd) begin
                        state    <= LDAC;
                        dac_ldac <= 1'b0;
                        pending  <= 1'b0;
                    end else begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                LDAC: if (w_end) begin
                    state    <= IDLE;
                    dac_ldac <= 1'b1;
                    Busy     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mercury2_dac_spi.sv
// tb_mercury2_dac_spi: checks SPI frames, Busy/LDAC timing and readback on three parameter sets.
module tb_mercury2_dac_spi;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [2:0] trig = '0;
    logic       chn = 1'b0, upd = 1'b0;
    logic [9:0] din = '0;
    logic [2:0] busy, csn, sdi, sck, ldac;
    logic [9:0] v0a, v1a, v0b, v1b;
    logic [7:0] v0c, v1c;
    logic [15:0] exp_q[3][$];
    int vectors = 0, errors = 0;
    int run[3] = '{0, 0, 0}, last[3] = '{0, 0, 0}, frames[3] = '{0, 0, 0};
    int lpulse[3] = '{0, 0, 0}, lclks[3] = '{0, 0, 0};

    typedef struct { logic ch; logic [9:0] d; logic [15:0] f; } vec_t;
    vec_t tbl[5];

    always #10 clk = ~clk;

    mercury2_dac_spi dut0 (.clk_50MHZ(clk), .rst_n(rst_n), .trigger(trig[0]), .channel(chn), .Din(din),
        .update(upd), .Busy(busy[0]), .dac_csn(csn[0]), .dac_sdi(sdi[0]), .dac_sck(sck[0]),
        .dac_ldac(ldac[0]), .value0(v0a), .value1(v1a));
    mercury2_dac_spi #(.SCK_DIV(1), .GAIN_2X(1'b1)) dut1 (.clk_50MHZ(clk), .rst_n(rst_n), .trigger(trig[1]),
        .channel(chn), .Din(din), .update(upd), .Busy(busy[1]), .dac_csn(csn[1]), .dac_sdi(sdi[1]),
        .dac_sck(sck[1]), .dac_ldac(ldac[1]), .value0(v0b), .value1(v1b));
    mercury2_dac_spi #(.DATA_WIDTH(8), .LDAC_MODE(1'b1)) dut2 (.clk_50MHZ(clk), .rst_n(rst_n), .trigger(trig[2]),
        .channel(chn), .Din(din[7:0]), .update(upd), .Busy(busy[2]), .dac_csn(csn[2]), .dac_sdi(sdi[2]),
        .dac_sck(sck[2]), .dac_ldac(ldac[2]), .value0(v0c), .value1(v1c));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : mon
        logic [15:0] sh = '0;
        int n = 0;
        always @(posedge sck[g] or posedge csn[g]) begin
            if (csn[g] === 1'b1) begin
                if (rst_n === 1'b1 && n > 0) begin
                    frames[g]++;
                    if (exp_q[g].size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL frame%0d: got unexpected %h want none", g, sh);
                    end else begin
                        check("frame", {16'h0, sh}, {16'h0, exp_q[g].pop_front()});
                        check("sck_edges", n, 16);
                    end
                end
                sh = '0;
                n = 0;
            end else begin
                sh = {sh[14:0], sdi[g]};
                n++;
            end
        end
        always @(negedge clk) begin
            if (busy[g] === 1'b1) run[g]++;
            else if (run[g] != 0) begin
                last[g] = run[g];
                run[g] = 0;
            end
            if (rst_n === 1'b1 && ldac[g] === 1'b0) begin
                lclks[g]++;
                check("ldac_while_csn_high", {31'h0, csn[g]}, 1);
            end
        end
        always @(negedge ldac[g]) lpulse[g]++;
    end

    task automatic write(input int g, input logic ch, input logic [9:0] d, input logic [15:0] f, input bit push);
        trig[g] = 1'b1;
        chn = ch;
        din = d;
        if (push) exp_q[g].push_back(f);
        @(negedge clk);
        trig[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int c = 0;
        while (busy[g] && c < 1000) begin
            @(negedge clk);
            c++;
        end
        check("busy_timeout", {31'h0, busy[g]}, 0);
    endtask

    task automatic pulse_upd;
        upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
    endtask

    initial begin
        int p, q, r;
        tbl[0] = '{ch: 1'b0, d: 10'h2AB, f: 16'h3AAC};
        tbl[1] = '{ch: 1'b1, d: 10'h155, f: 16'hB554};
        tbl[2] = '{ch: 1'b0, d: 10'h000, f: 16'h3000};
        tbl[3] = '{ch: 1'b1, d: 10'h3FF, f: 16'hBFFC};
        tbl[4] = '{ch: 1'b0, d: 10'h001, f: 16'h3004};
        repeat (3) @(negedge clk);
        check("rst_csn", {31'h0, csn[0]}, 1);
        check("rst_sck", {31'h0, sck[0]}, 0);
        check("rst_sdi", {31'h0, sdi[0]}, 0);
        check("rst_ldac", {31'h0, ldac[0]}, 1);
        check("rst_busy", {31'h0, busy[0]}, 0);
        check("rst_value0", {22'h0, v0a}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            p = lpulse[0];
            q = lclks[0];
            write(0, tbl[i].ch, tbl[i].d, tbl[i].f, 1'b1);
            wait_idle(0);
            @(negedge clk);
            check("busy_len", last[0], 72);
            check("ldac_pulses", lpulse[0] - p, 1);
            check("ldac_clks", lclks[0] - q, 2);
            check("readback", {22'h0, tbl[i].ch ? v1a : v0a}, {22'h0, tbl[i].d});
        end
        write(1, 1'b1, 10'h3FF, 16'h9FFC, 1'b1);
        wait_idle(1);
        @(negedge clk);
        check("b_busy_len", last[1], 37);
        check("b_value1", {22'h0, v1b}, 32'h3FF);
        check("b_value0", {22'h0, v0b}, 0);
        p = lpulse[2];
        r = lpulse[0];
        write(2, 1'b0, 10'h080, 16'h3800, 1'b1);
        wait_idle(2);
        @(negedge clk);
        check("c_busy_len0", last[2], 70);
        write(2, 1'b1, 10'h040, 16'hB400, 1'b1);
        wait_idle(2);
        @(negedge clk);
        check("c_busy_len1", last[2], 70);
        check("c_no_ldac", lpulse[2] - p, 0);
        q = lclks[2];
        pulse_upd();
        wait_idle(2);
        @(negedge clk);
        check("c_upd_busy", last[2], 2);
        check("c_upd_pulse", lpulse[2] - p, 1);
        check("c_upd_clks", lclks[2] - q, 2);
        check("mode0_ignores_update", lpulse[0] - r, 0);
        check("c_value0", {24'h0, v0c}, 32'h80);
        check("c_value1", {24'h0, v1c}, 32'h40);
        write(2, 1'b0, 10'h011, 16'h3110, 1'b1);
        repeat (20) @(negedge clk);
        pulse_upd();
        repeat (20) @(negedge clk);
        pulse_upd();
        wait_idle(2);
        @(negedge clk);
        check("c_mid_busy", last[2], 72);
        check("c_mid_pulse", lpulse[2] - p, 2);
        p = frames[0];
        write(0, 1'b0, 10'h2AB, 16'h3AAC, 1'b1);
        repeat (8) @(negedge clk);
        write(0, 1'b0, 10'h155, 16'h0, 1'b0);
        wait_idle(0);
        write(0, 1'b1, 10'h100, 16'hB400, 1'b1);
        check("b2b_first_len", last[0], 72);
        check("b2b_busy", {31'h0, busy[0]}, 1);
        check("ignored_value0", {22'h0, v0a}, 32'h2AB);
        wait_idle(0);
        @(negedge clk);
        check("b2b_second_len", last[0], 72);
        check("frames_sent", frames[0] - p, 2);
        check("b2b_value1", {22'h0, v1a}, 32'h100);
        write(0, 1'b0, 10'h3FF, 16'h3FFC, 1'b1);
        repeat (31) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_csn", {31'h0, csn[0]}, 1);
        check("mid_rst_sck", {31'h0, sck[0]}, 0);
        check("mid_rst_sdi", {31'h0, sdi[0]}, 0);
        check("mid_rst_ldac", {31'h0, ldac[0]}, 1);
        check("mid_rst_busy", {31'h0, busy[0]}, 0);
        check("mid_rst_value0", {22'h0, v0a}, 0);
        check("mid_rst_value1", {22'h0, v1a}, 0);
        exp_q[0].delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        write(0, 1'b0, 10'h2AB, 16'h3AAC, 1'b1);
        wait_idle(0);
        @(negedge clk);
        check("post_rst_len", last[0], 72);
        check("post_rst_value0", {22'h0, v0a}, 32'h2AB);
        for (int g = 0; g < 3; g++) check("frames_missing", exp_q[g].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end
endmodule

// File: doc/mercury2_dac_spi.md
# mercury2_dac_spi

Parametrised SPI driver for the Mercury2 baseboard dual-channel DAC (MCP48x2 family). It replaces the Busy-only simulation model with a real 16-bit SPI frame generator, and keeps the same trigger/channel/Din/Busy handshake so upstream logic is unchanged. It adds four things: selectable data width, a programmable SCK rate, per-channel readback, and a synchronous-update mode that loads both channels together on one LDAC strobe.

## Interface
- DATA_WIDTH, 10: DAC resolution, 8..12. Din is left-justified into the 12-bit data field.
- SCK_DIV, 2: clk_50MHZ cycles per SCK half-period, ≥1. The default gives 12.5 MHz SCK.
- LDAC_MODE, 0: 0 = LDAC pulse after every frame; 1 = LDAC pulse only on `update`.
- LDAC_WIDTH, 2: LDAC low pulse width in clocks, ≥1.
- GAIN_2X, 0: 1 selects 2x output gain (GA bit = 0).

Ports:
- clk_50MHZ  in  1  50 MHz onboard oscillator, the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- trigger  in  1  single-cycle request to write Din to `channel`.
- channel  in  1  0 = DAC0/A, 1 = DAC1/B.
- Din  in  DATA_WIDTH  sample for the DAC.
- update  in  1  LDAC_MODE=1 only: request an LDAC pulse. Ignored when LDAC_MODE=0.
- Busy  out  1  high while a frame or LDAC pulse is in progress.
- dac_csn  out  1  SPI chip select, active low.
- dac_sdi  out  1  SPI data, MSB first.
- dac_sck  out  1  SPI clock, idle low.
- dac_ldac  out  1  DAC latch strobe, active low.
- value0  out  DATA_WIDTH  last Din accepted for channel 0.
- value1  out  DATA_WIDTH  last Din accepted for channel 1.

## Operation
- Frame word, 16 bits: {channel, 0, ~GAIN_2X, 1 (SHDN inactive), Din, (12-DATA_WIDTH) zeros}.
- **IDLE**
  - Outputs: csn=1, sck=0, sdi=0, ldac=1, Busy=0.
  - trigger=1 is accepted: the frame word is loaded into the shift register, and value0 or value1 is updated (per channel) on the same edge. Next state SETUP.
- **SETUP**: csn=0, sck=0, sdi = bit15. Lasts SCK_DIV clocks.
- **SHIFT**: 16 bits, MSB first.
  - Each bit is SCK_DIV clocks with sck=0, then SCK_DIV clocks with sck=1.
  - sdi updates only at the start of a low phase, so it is stable across every rising SCK edge.
- **HOLD**: csn=0, sck=0 for SCK_DIV clocks.
- **GAP**: csn=1 for SCK_DIV clocks (minimum CS-high time).
  - LDAC_MODE=0: go to LDAC.
  - LDAC_MODE=1: go to LDAC if an update is pending, otherwise go to IDLE.
- **LDAC**: ldac=0 for LDAC_WIDTH clocks, csn=1. Clears the pending-update flag. Returns to IDLE.
- **update in LDAC_MODE=1**
  - In IDLE with no trigger: go directly to LDAC.
  - Received while Busy, or in the same cycle as a trigger: sets a one-deep pending flag. The pulse is issued after that frame's GAP. Multiple updates collapse into one pulse.
- **trigger while Busy**: ignored. No capture, no change to value0/value1. Upstream must wait for Busy=0.
- **Reset**: rst_n low asynchronously forces IDLE and the idle output levels. It also clears value0, value1, the pending flag, the shift register and the counters. An in-flight frame is abandoned: csn rises immediately and the DAC discards the partial word.

## Timing
- Busy rises on the clock edge that accepts the trigger (visible the cycle after trigger), and falls on entry to IDLE.
- With D=SCK_DIV and W=LDAC_WIDTH:
  - Frame length: 35·D clocks (D setup + 32·D shift + D hold + D gap).
  - Busy duration: 35·D+W clocks with LDAC, 35·D without. Defaults give 72 and 70 clocks.
  - An update-only pulse from IDLE holds Busy for W clocks.
- A new trigger presented in the first IDLE cycle is accepted, so back-to-back writes have zero idle gap.
- dac_sck has exactly 16 rising edges per frame, all while csn=0.
- All outputs are registered. There is no combinational path from inputs to SPI pins.

## Test plan
- **Default parameters, ch0 write**: trigger, channel=0, Din=0x2AB.
  - SPI frame captured on rising SCK edges is 0x3AAC, with 16 SCK edges.
  - Busy is high for 72 clocks, ldac is low for 2 clocks after csn rises, value0=0x2AB.
- **Gain and channel B**: ch1, Din=0x3FF, GAIN_2X=1, SCK_DIV=1.
  - Frame is 0x9FFC, SCK period is 2 clocks, Busy is high for 37 clocks, value1=0x3FF, value0 is unchanged.
- **DATA_WIDTH=8, LDAC_MODE=1**: write ch0 0x80, write ch1 0x40, then update.
  - Frames are 0x3800 and 0xB400.
  - No LDAC during the frames. A single 2-clock LDAC pulse follows the update.
  - A second run with update asserted mid-frame gives one pulse after the GAP.
- **Trigger while Busy**: a second trigger with Din=0x155 at clock 10 of a frame is ignored.
  - Exactly one frame is sent and value0 keeps the first value.
  - A trigger in the first IDLE cycle starts the next frame immediately.
- **Reset mid-frame**: rst_n low during bit 7 of SHIFT.
  - In the same cycle: csn=1, sck=0, sdi=0, ldac=1, Busy=0, value0=value1=0.
  - After release, a normal write completes correctly.
